// File: rtl/multi_cycle_mem_responder_pkg.sv
// Shared types and constants for the multi-cycle memory responder.
package multi_cycle_mem_responder_pkg;

  localparam int WORD_BYTES = 4;
  localparam int OFS_W      = $clog2(WORD_BYTES);

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_WAIT = 2'd1,
    MS_RESP = 2'd2
  } ms_state_t;

endpackage

// File: rtl/multi_cycle_mem_responder_if.sv
// Core <-> memory handshake bundle. The core drives the master side.
interface multi_cycle_mem_responder_if #(
  parameter int ADDR_W = 32
);
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       din;
  logic [31:0]       dout;
  logic              mem_ready;
  logic              mem_err;
  logic              busy;

  modport master (
    output mem_read, mem_write, addr, din,
    input  dout, mem_ready, mem_err, busy
  );

  modport slave (
    input  mem_read, mem_write, addr, din,
    output dout, mem_ready, mem_err, busy
  );
endinterface

// File: rtl/multi_cycle_mem_responder_mem_array.sv
// Word-addressed storage: asynchronous read port, synchronous write port.
// Contents are never cleared by reset.
module multi_cycle_mem_responder_mem_array #(
  parameter int DEPTH_WORDS = 16384,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  assign rdata = mem[raddr];

  // Commit one word when enabled.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

endmodule

// File: rtl/multi_cycle_mem_responder.sv
// Memory-side responder for the multi-cycle core: accepts a read/write strobe,
// waits a fixed LATENCY (1..15), then pulses mem_ready for one cycle.
//
// state   | meaning
// IDLE    | waiting for mem_read/mem_write; request latched on accept
// WAIT    | latency countdown, bus inputs ignored
// RESP    | one-cycle response; a write commits on the edge leaving it
module multi_cycle_mem_responder
  import multi_cycle_mem_responder_pkg::*;
#(
  parameter int LATENCY     = 2,
  parameter int DEPTH_WORDS = 16384,
  parameter int ADDR_W      = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  multi_cycle_mem_responder_if.slave   bus
);

  localparam int IDX_W  = $clog2(DEPTH_WORDS);
  localparam int WIDX_W = ADDR_W - OFS_W;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  ms_state_t state, state_nx;
  logic [3:0] cnt;

  logic [IDX_W-1:0] req_idx;
  logic [31:0]      req_din;
  logic             req_write, req_both, req_fault;

  logic [31:0] dout_q;
  logic        ready_q, err_q;

  logic [WIDX_W-1:0] live_word;
  logic              live_fault, accept, enter_resp;
  logic [IDX_W-1:0]  cur_idx;
  logic              cur_write, cur_both, cur_fault;
  logic              arr_we;
  logic [31:0]       arr_rdata;

  // Live decode of the bus; the word index compare catches addresses past the array.
  assign live_word  = bus.addr[ADDR_W-1:OFS_W];
  assign live_fault = (bus.addr[OFS_W-1:0] != '0) || (live_word >= WIDX_W'(DEPTH_WORDS));
  assign accept     = (state == MS_IDLE) && (bus.mem_read || bus.mem_write);

  // With LATENCY==1 the response is loaded straight from IDLE, before the latch holds
  // the request, so the response path selects live inputs in IDLE.
  assign cur_idx   = (state == MS_IDLE) ? live_word[IDX_W-1:0] : req_idx;
  assign cur_write = (state == MS_IDLE) ? bus.mem_write : req_write;
  assign cur_both  = (state == MS_IDLE) ? (bus.mem_read && bus.mem_write) : req_both;
  assign cur_fault = (state == MS_IDLE) ? live_fault : req_fault;

  // Gated by reset so an access aborted in RESP never commits.
  assign arr_we = (state == MS_RESP) && req_write && !req_fault && reset;

  multi_cycle_mem_responder_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_mem_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (req_idx),
    .wdata (req_din),
    .raddr (cur_idx),
    .rdata (arr_rdata)
  );

  // Next-state selection.
  always_comb begin
    state_nx = state;
    unique case (state)
      MS_IDLE: if (accept) state_nx = (LATENCY == 1) ? MS_RESP : MS_WAIT;
      MS_WAIT: if (cnt == 4'd1) state_nx = MS_RESP;
      MS_RESP: state_nx = MS_IDLE;
      default: state_nx = MS_IDLE;
    endcase
  end

  assign enter_resp = (state_nx == MS_RESP);

  // State, latency counter and registered response outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= MS_IDLE;
      cnt     <= 4'd0;
      dout_q  <= 32'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      ready_q <= enter_resp;
      err_q   <= enter_resp && (cur_fault || cur_both);
      if (accept) cnt <= CNT_INIT;
      else if (state == MS_WAIT) cnt <= cnt - 4'd1;
      if (enter_resp) begin
        if (cur_fault) dout_q <= 32'd0;
        else if (!cur_write) dout_q <= arr_rdata;
      end
    end
  end

  // Request latch; a write on both strobes is treated as a store.
  always_ff @(posedge clk) begin
    if (accept) begin
      req_idx   <= live_word[IDX_W-1:0];
      req_din   <= bus.din;
      req_write <= bus.mem_write;
      req_both  <= bus.mem_read && bus.mem_write;
      req_fault <= live_fault;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.mem_ready = ready_q;
  assign bus.mem_err   = err_q;
  assign bus.busy      = (state != MS_IDLE);

endmodule

// File: tb/tb_multi_cycle_mem_responder.sv
// Bench for multi_cycle_mem_responder: four instances (LATENCY 2, 3, 1, 15) share one
// request stream; a per-instance transaction model predicts every cycle's outputs.
module tb_multi_cycle_mem_responder;

  localparam int NDUT  = 4;
  localparam int DEPTH = 16384;

  function automatic int lat_of(int i);
    case (i)
      0:       return 2;
      1:       return 3;
      2:       return 1;
      default: return 15;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] din = 32'd0;

  logic [NDUT-1:0]       rdy_v, err_v, busy_v;
  logic [NDUT-1:0][31:0] dout_v;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    multi_cycle_mem_responder_if #(.ADDR_W(32)) bus ();
    assign bus.mem_read  = mem_read;
    assign bus.mem_write = mem_write;
    assign bus.addr      = addr;
    assign bus.din       = din;
    assign rdy_v[g]  = bus.mem_ready;
    assign err_v[g]  = bus.mem_err;
    assign busy_v[g] = bus.busy;
    assign dout_v[g] = bus.dout;

    multi_cycle_mem_responder #(
      .LATENCY     (lat_of(g)),
      .DEPTH_WORDS (DEPTH),
      .ADDR_W      (32)
    ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );
  end

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Reference model: per instance, an accepted request at edge t responds after edge
  // t+L-1 and (for a good write) commits at the following edge.
  int unsigned t = 0;
  bit          chk_en = 1'b0;
  bit          act   [NDUT];
  int unsigned resp_e[NDUT];
  bit          l_wr  [NDUT];
  bit          l_both[NDUT];
  bit          l_flt [NDUT];
  int unsigned l_word[NDUT];
  logic [31:0] l_din [NDUT];
  logic [31:0] mmem  [NDUT][32];
  bit          m_rdy [NDUT];
  bit          m_err [NDUT];
  logic [31:0] m_dout[NDUT];

  always @(posedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      if (!reset) begin
        act[d] = 1'b0; m_rdy[d] = 1'b0; m_err[d] = 1'b0; m_dout[d] = 32'd0;
      end else begin
        m_rdy[d] = 1'b0;
        m_err[d] = 1'b0;
        if (act[d] && t == resp_e[d] + 1) begin
          if (l_wr[d] && !l_flt[d]) mmem[d][l_word[d]] = l_din[d];
          act[d] = 1'b0;
        end else if (!act[d] && (mem_read || mem_write)) begin
          act[d]    = 1'b1;
          resp_e[d] = t + lat_of(d) - 1;
          l_wr[d]   = mem_write;
          l_both[d] = mem_read && mem_write;
          l_word[d] = addr >> 2;
          l_flt[d]  = (addr[1:0] != 2'b00) || ((addr >> 2) >= DEPTH);
          l_din[d]  = din;
        end
        if (act[d] && t == resp_e[d]) begin
          m_rdy[d] = 1'b1;
          m_err[d] = l_flt[d] || l_both[d];
          if (l_flt[d]) m_dout[d] = 32'd0;
          else if (!l_wr[d]) m_dout[d] = mmem[d][l_word[d]];
        end
      end
    end
    t++;
    chk_en = 1'b1;
  end

  // Compare every instance's outputs mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < NDUT; d++) begin
        check_val($sformatf("rdy%0d", d),  32'(rdy_v[d]),  32'(m_rdy[d]));
        check_val($sformatf("err%0d", d),  32'(err_v[d]),  32'(m_err[d]));
        check_val($sformatf("busy%0d", d), 32'(busy_v[d]), 32'(act[d]));
        check_val($sformatf("dout%0d", d), dout_v[d],      m_dout[d]);
      end
    end
  end

  // One request: strobes held for 'hold' sampled edges, then a gap long enough for
  // the slowest instance to finish and commit.
  task automatic req(input bit rd, input bit wr, input logic [31:0] a,
                     input logic [31:0] d, input int hold);
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    din       = d;
    repeat (hold) @(negedge clk);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    repeat (18) @(negedge clk);
  endtask

  function automatic logic [31:0] pick_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
    if (r == 1) return ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFC
                                                    : 32'(DEPTH * 4 + $urandom_range(0, 100) * 4);
    return 32'($urandom_range(0, 31) * 4);
  endfunction

  initial begin
    int op;
    int hold;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int w = 0; w < 32; w++) begin
      if (w == 4)       req(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1);
      else if (w == 16) req(1'b0, 1'b1, 32'h40, 32'h0BAD_0040, 1);
      else              req(1'b0, 1'b1, 32'(w * 4), $urandom, 1);
    end

    req(1'b1, 1'b0, 32'h10, 32'd0, 1);
    req(1'b1, 1'b0, 32'h20, 32'd0, 1);
    req(1'b0, 1'b1, 32'h20, 32'h1234_5678, 1);
    req(1'b1, 1'b0, 32'h20, 32'd0, 1);
    req(1'b1, 1'b0, 32'h13, 32'd0, 1);
    req(1'b1, 1'b0, 32'(DEPTH * 4), 32'd0, 1);
    req(1'b0, 1'b1, 32'h17, 32'hFFFF_0000, 1);
    req(1'b1, 1'b0, 32'h14, 32'd0, 1);
    req(1'b1, 1'b0, 32'h10, 32'd0, 1);

    mem_write = 1'b1;
    addr      = 32'h40;
    din       = 32'h5555_AAAA;
    @(negedge clk);
    mem_write = 1'b0;
    reset     = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (18) @(negedge clk);
    req(1'b1, 1'b0, 32'h40, 32'd0, 1);

    req(1'b1, 1'b0, 32'h10, 32'd0, 12);
    req(1'b1, 1'b1, 32'h8, 32'h0000_00A5, 1);
    req(1'b1, 1'b0, 32'h8, 32'd0, 1);

    for (int i = 0; i < 300; i++) begin
      op   = $urandom_range(0, 9);
      hold = ($urandom_range(0, 1) == 0) ? 1 : $urandom_range(2, 40);
      if (op == 0)     req(1'b1, 1'b1, pick_addr(), $urandom, hold);
      else if (op < 5) req(1'b0, 1'b1, pick_addr(), $urandom, hold);
      else             req(1'b1, 1'b0, pick_addr(), 32'd0, hold);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
